// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - ID/EX pipeline register bus (ID-side inputs, EX-side outputs, hazard signal)
// Optional perf counter signals present when ID_EX_PERF_CNT_EN is defined.
interface id_ex_pipe_if #(
  parameter int CTRL_W = 16
);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs0;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_reg_write;
  logic [31:0]       rf_rd0;
  logic [31:0]       rf_rd1;
  logic [1:0]        fwd_a_id;
  logic [1:0]        fwd_b_id;
  logic [31:0]       mem_alu_y;
  logic [31:0]       mem_load_data;
  logic              branch_flush;
  logic              stall_in;
  logic              stall_if_id;
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_a;
  logic [31:0]       ex_b;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs0;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]       perf_bubbles;
  logic [31:0]       perf_flushes;
`endif

  modport master (
    output id_valid, id_pc, id_imm, id_rs0, id_rs1, id_rd, id_ctrl,
           id_mem_read, id_mem_write, id_reg_write, rf_rd0, rf_rd1,
           fwd_a_id, fwd_b_id, mem_alu_y, mem_load_data, branch_flush, stall_in,
    input  stall_if_id, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_pc, ex_a, ex_b, ex_imm, ex_rs0, ex_rs1, ex_rd, ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
    , input perf_bubbles, perf_flushes
`endif
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs0, id_rs1, id_rd, id_ctrl,
           id_mem_read, id_mem_write, id_reg_write, rf_rd0, rf_rd1,
           fwd_a_id, fwd_b_id, mem_alu_y, mem_load_data, branch_flush, stall_in,
    output stall_if_id, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_pc, ex_a, ex_b, ex_imm, ex_rs0, ex_rs1, ex_rd, ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
    , output perf_bubbles, perf_flushes
`endif
  );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with operand forwarding mux and load-use bubble control
// Optional bubble/flush performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe #(
  parameter int CTRL_W = 16
) (
  input  logic clk,
  input  logic rstn,
  id_ex_pipe_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [31:0]       pc;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       imm;
    logic [4:0]        rs0;
    logic [4:0]        rs1;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t         ex_q;
  ex_t         ex_d;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        lu;

  // Select 2 is an unused encoding and falls back to the register file.
  function automatic logic [31:0] fwd_pick(input logic [4:0] rs, input logic [1:0] sel,
                                           input logic [31:0] rf, input logic [31:0] alu,
                                           input logic [31:0] ld);
    logic [31:0] v;
    case (sel)
      2'd1:    v = ld;
      2'd3:    v = alu;
      default: v = rf;
    endcase
    return (rs == 5'd0) ? 32'd0 : v;
  endfunction

  // Operand mux: x0 forces zero regardless of the forwarding select.
  always_comb begin
    op_a = fwd_pick(bus.id_rs0, bus.fwd_a_id, bus.rf_rd0, bus.mem_alu_y, bus.mem_load_data);
    op_b = fwd_pick(bus.id_rs1, bus.fwd_b_id, bus.rf_rd1, bus.mem_alu_y, bus.mem_load_data);
  end

  assign lu = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.id_valid &
              ((ex_q.rd == bus.id_rs0) | (ex_q.rd == bus.id_rs1));

  // A flushed ID instruction is being killed, so no point holding IF/ID for it.
  assign bus.stall_if_id = lu & ~bus.branch_flush & ~bus.stall_in;

  // Next EX state: flush beats freeze, freeze beats load-use bubble.
  always_comb begin
    ex_d = ex_q;
    if (bus.branch_flush) begin
      ex_d = '0;
    end else if (bus.stall_in) begin
      ex_d = ex_q;
    end else if (lu) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = bus.id_valid;
      ex_d.mem_read  = bus.id_valid & bus.id_mem_read;
      ex_d.mem_write = bus.id_valid & bus.id_mem_write;
      ex_d.reg_write = bus.id_valid & bus.id_reg_write;
      ex_d.pc        = bus.id_pc;
      ex_d.a         = op_a;
      ex_d.b         = op_b;
      ex_d.imm       = bus.id_imm;
      ex_d.rs0       = bus.id_rs0;
      ex_d.rs1       = bus.id_rs1;
      ex_d.rd        = bus.id_rd;
      ex_d.ctrl      = bus.id_ctrl;
    end
  end

  // EX stage register; reset empties the pipe and forgets any pending bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_a         = ex_q.a;
  assign bus.ex_b         = ex_q.b;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs0       = ex_q.rs0;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_ctrl      = ex_q.ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles_q;
  logic [31:0] perf_bubbles_d;
  logic [31:0] perf_flushes_q;
  logic [31:0] perf_flushes_d;

  // Saturating counters; flush and load-use bubbles are mutually exclusive per edge.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    if (bus.branch_flush) begin
      if (perf_flushes_q != 32'hFFFF_FFFF) perf_flushes_d = perf_flushes_q + 32'd1;
    end else if (!bus.stall_in && lu) begin
      if (perf_bubbles_q != 32'hFFFF_FFFF) perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_bubbles_q <= 32'd0;
      perf_flushes_q <= 32'd0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign bus.perf_bubbles = perf_bubbles_q;
  assign bus.perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - randomized and directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  id_ex_pipe_if #(.CTRL_W(16)) pif ();

  id_ex_pipe #(.CTRL_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the EX stage must hold, from the pipeline rules.
  typedef struct packed {
    logic        v, mr, mw, rw;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs0, rs1, rd;
    logic [15:0] ctrl;
  } ex_t;

  ex_t         m;
  logic [31:0] m_bub;
  logic [31:0] m_fl;

  function automatic logic m_hazard();
    return m.v && m.mr && (m.rd != 0) && pif.id_valid &&
           (m.rd == pif.id_rs0 || m.rd == pif.id_rs1);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [1:0] sel,
                                          input logic [31:0] rf);
    if (rs == 0)  return 32'd0;
    if (sel == 1) return pif.mem_load_data;
    if (sel == 3) return pif.mem_alu_y;
    return rf;
  endfunction

  function automatic ex_t from_id();
    ex_t t;
    t.v    = pif.id_valid;
    t.mr   = pif.id_valid && pif.id_mem_read;
    t.mw   = pif.id_valid && pif.id_mem_write;
    t.rw   = pif.id_valid && pif.id_reg_write;
    t.pc   = pif.id_pc;
    t.imm  = pif.id_imm;
    t.a    = operand(pif.id_rs0, pif.fwd_a_id, pif.rf_rd0);
    t.b    = operand(pif.id_rs1, pif.fwd_b_id, pif.rf_rd1);
    t.rs0  = pif.id_rs0;
    t.rs1  = pif.id_rs1;
    t.rd   = pif.id_rd;
    t.ctrl = pif.id_ctrl;
    return t;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m     <= '0;
      m_bub <= 0;
      m_fl  <= 0;
    end else if (pif.branch_flush) begin
      m    <= '0;
      m_fl <= m_fl + 1;
    end else if (pif.stall_in) begin
      m <= m;
    end else if (m_hazard()) begin
      m     <= '0;
      m_bub <= m_bub + 1;
    end else begin
      m <= from_id();
    end
  end

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    check("cmp_stall", pif.stall_if_id,
          {63'd0, m_hazard() && !pif.branch_flush && !pif.stall_in && rstn});
    check("cmp_valid", pif.ex_valid, m.v);
    check("cmp_mr",    pif.ex_mem_read, m.mr);
    check("cmp_mw",    pif.ex_mem_write, m.mw);
    check("cmp_rw",    pif.ex_reg_write, m.rw);
    check("cmp_pc",    pif.ex_pc, m.pc);
    check("cmp_a",     pif.ex_a, m.a);
    check("cmp_b",     pif.ex_b, m.b);
    check("cmp_imm",   pif.ex_imm, m.imm);
    check("cmp_rs0",   pif.ex_rs0, m.rs0);
    check("cmp_rs1",   pif.ex_rs1, m.rs1);
    check("cmp_rd",    pif.ex_rd, m.rd);
    check("cmp_ctrl",  pif.ex_ctrl, m.ctrl);
`ifdef ID_EX_PERF_CNT_EN
    check("cmp_pbub",  pif.perf_bubbles, m_bub);
    check("cmp_pfl",   pif.perf_flushes, m_fl);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    pif.id_valid = 0; pif.id_pc = 0; pif.id_imm = 0;
    pif.id_rs0 = 0; pif.id_rs1 = 0; pif.id_rd = 0; pif.id_ctrl = 0;
    pif.id_mem_read = 0; pif.id_mem_write = 0; pif.id_reg_write = 0;
    pif.rf_rd0 = 0; pif.rf_rd1 = 0; pif.fwd_a_id = 0; pif.fwd_b_id = 0;
    pif.mem_alu_y = 0; pif.mem_load_data = 0;
    pif.branch_flush = 0; pif.stall_in = 0;
  endtask

  task automatic instr(input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic is_load);
    pif.id_valid = 1; pif.id_rd = rd; pif.id_rs0 = rs0; pif.id_rs1 = rs1;
    pif.id_mem_read = is_load; pif.id_mem_write = 0; pif.id_reg_write = 1;
    pif.id_ctrl = 16'h00A5;
  endtask

  logic [31:0] bub0;
  logic [31:0] fl0;

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rstn = 0;
    #12;
    check("reset_valid", pif.ex_valid, 0);
    check("reset_stall", pif.stall_if_id, 0);
    check("reset_pc",    pif.ex_pc, 0);
    rstn = 1;
    cyc();

    // Forward select
    instr(5'd9, 5'd5, 5'd0, 0);
    pif.rf_rd0 = 32'h11; pif.mem_alu_y = 32'h22; pif.mem_load_data = 32'h33;
    pif.fwd_a_id = 0; cyc(); check("fwd_rf",  pif.ex_a, 32'h11);
    pif.fwd_a_id = 3; cyc(); check("fwd_alu", pif.ex_a, 32'h22);
    pif.fwd_a_id = 1; cyc(); check("fwd_ld",  pif.ex_a, 32'h33);
    pif.fwd_a_id = 2; cyc(); check("fwd_2",   pif.ex_a, 32'h11);
    pif.id_rs0 = 0; pif.fwd_a_id = 3; cyc(); check("fwd_x0", pif.ex_a, 32'h0);

    // Load-use: lw x7, then add x8, x7, x1
    instr(5'd7, 5'd1, 5'd2, 1); pif.fwd_a_id = 0;
    cyc();
    instr(5'd8, 5'd7, 5'd1, 0);
    #1 check("lu_stall", pif.stall_if_id, 1);
    cyc();
    check("lu_bub_valid", pif.ex_valid, 0);
    check("lu_bub_rw",    pif.ex_reg_write, 0);
    check("lu_stall_off", pif.stall_if_id, 0);
    pif.fwd_a_id = 1; pif.mem_load_data = 32'hCAFE_0001;
    cyc();
    check("lu_a",  pif.ex_a, 32'hCAFE_0001);
    check("lu_rd", pif.ex_rd, 8);
    check("lu_v",  pif.ex_valid, 1);

    // Load to x0 never stalls
    pif.fwd_a_id = 0;
    instr(5'd0, 5'd3, 5'd4, 1); cyc();
    instr(5'd6, 5'd0, 5'd0, 0);
    #1 check("x0_stall", pif.stall_if_id, 0);
    cyc(); check("x0_valid", pif.ex_valid, 1);

    // Flush together with a load-use hazard
    instr(5'd7, 5'd1, 5'd2, 1); cyc();
`ifdef ID_EX_PERF_CNT_EN
    bub0 = pif.perf_bubbles; fl0 = pif.perf_flushes;
`endif
    instr(5'd8, 5'd7, 5'd1, 0); pif.branch_flush = 1;
    #1 check("fl_stall", pif.stall_if_id, 0);
    cyc(); pif.branch_flush = 0;
    check("fl_valid", pif.ex_valid, 0);
`ifdef ID_EX_PERF_CNT_EN
    check("fl_pfl",  pif.perf_flushes, fl0 + 1);
    check("fl_pbub", pif.perf_bubbles, bub0);
`endif

    // Freeze for three edges while ID changes
    instr(5'd10, 5'd11, 5'd12, 0); pif.id_pc = 32'h100; cyc();
    check("frz_pc0", pif.ex_pc, 32'h100);
    pif.stall_in = 1;
    pif.id_pc = 32'h200; cyc(); check("frz_pc1", pif.ex_pc, 32'h100);
    pif.id_pc = 32'h300; cyc(); check("frz_pc2", pif.ex_pc, 32'h100);
    pif.id_pc = 32'h400; cyc(); check("frz_pc3", pif.ex_pc, 32'h100);
    pif.stall_in = 0; cyc(); check("frz_pc4", pif.ex_pc, 32'h400);

    // Async reset mid-cycle
    pif.id_pc = 32'h500; cyc();
    #1 rstn = 0;
    #1;
    check("ar_valid", pif.ex_valid, 0);
    check("ar_pc",    pif.ex_pc, 0);
    check("ar_rd",    pif.ex_rd, 0);
    check("ar_stall", pif.stall_if_id, 0);
`ifdef ID_EX_PERF_CNT_EN
    check("ar_pbub", pif.perf_bubbles, 0);
    check("ar_pfl",  pif.perf_flushes, 0);
`endif
    cyc();
    check("ar_hold", pif.ex_pc, 0);
    rstn = 1;

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      pif.id_valid      = ($urandom_range(0, 9) != 0);
      pif.id_pc         = $urandom;
      pif.id_imm        = $urandom;
      pif.id_rs0        = 5'($urandom_range(0, 3));
      pif.id_rs1        = 5'($urandom_range(0, 3));
      pif.id_rd         = 5'($urandom_range(0, 3));
      pif.id_ctrl       = 16'($urandom);
      pif.id_mem_read   = ($urandom_range(0, 2) == 0);
      pif.id_mem_write  = ($urandom_range(0, 3) == 0);
      pif.id_reg_write  = ($urandom_range(0, 1) == 0);
      pif.rf_rd0        = $urandom;
      pif.rf_rd1        = $urandom;
      pif.fwd_a_id      = 2'($urandom_range(0, 3));
      pif.fwd_b_id      = 2'($urandom_range(0, 3));
      pif.mem_alu_y     = $urandom;
      pif.mem_load_data = $urandom;
      pif.branch_flush  = ($urandom_range(0, 9) == 0);
      pif.stall_in      = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rstn = 0;
        cyc();
        rstn = 1;
      end else begin
        cyc();
      end
    end

    idle();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register of the five-stage RISC-V core, with operand selection and load-use hazard control. Each cycle it picks the ID-stage source operands from the register file, the MEM-stage ALU result or the MEM-stage load data, as directed by the forwarding unit's ID-side selects. It latches the instruction into the EX stage, inserts a bubble and stalls IF/ID on a load-use hazard, and squashes the instruction on a branch flush.

## Interface
- `CTRL_W`, default 16: width of the opaque EX/MEM/WB control bundle carried through.
- `clk` input 1: clock, rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `id_valid` input 1: ID stage holds a real instruction.
- `id_pc`, `id_imm` input 32 each: PC and decoded immediate.
- `id_rs0`, `id_rs1`, `id_rd` input 5 each: register indices.
- `id_ctrl` input CTRL_W: control bundle.
- `id_mem_read`, `id_mem_write`, `id_reg_write` input 1 each: side-effect controls.
- `rf_rd0`, `rf_rd1` input 32 each: register-file read data.
- `fwd_a_id`, `fwd_b_id` input 2 each: operand select.
  - 0 = register file.
  - 1 = MEM load data.
  - 3 = MEM ALU result.
  - 2 = register file.
- `mem_alu_y`, `mem_load_data` input 32 each: MEM-stage forwarding sources.
- `branch_flush` input 1: EX resolved a taken branch or jump.
- `stall_in` input 1: global pipeline freeze.
- `stall_if_id` output 1: hold PC and IF/ID; load-use hazard.
- `ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write` output 1 each: registered controls.
- `ex_pc`, `ex_a`, `ex_b`, `ex_imm` output 32 each: registered PC, operands and immediate.
- `ex_rs0`, `ex_rs1`, `ex_rd` output 5 each: registered register indices.
- `ex_ctrl` output CTRL_W: registered control bundle.

## Operation
- **Operand mux** (combinational):
  - `op_a` = `id_rs0` == 0 ? 0 : select(`fwd_a_id`). `op_b` is formed the same way from `id_rs1` and `fwd_b_id`.
  - x0 always reads zero, whatever the select.
- **Load-use detect** (combinational):
  - `lu` = `ex_valid` & `ex_mem_read` & `ex_rd` != 0 & `id_valid` & (`ex_rd` == `id_rs0` | `ex_rd` == `id_rs1`).
  - `stall_if_id` = `lu` & ~`branch_flush` & ~`stall_in`.
- **Register update priority**, evaluated at each rising edge:
  1. `branch_flush`: load a bubble.
  2. `stall_in`: hold every register.
  3. `lu`: load a bubble.
  4. Otherwise: load the ID values, with `ex_a`/`ex_b` taken from `op_a`/`op_b`.
- **Bubble**:
  - `ex_valid`, `ex_mem_read`, `ex_mem_write` and `ex_reg_write` = 0.
  - `ex_ctrl` = 0 and `ex_rd` = 0.
  - The data fields are don't-care but are loaded with 0.
- **Invalid ID instruction**: when `id_valid` = 0 in normal load, the side-effect controls are loaded as 0.
- **Reset**: all outputs and registers go to 0 immediately on `rstn` low. `stall_if_id` = 0 during reset.

## Timing
- One cycle of latency from ID inputs to `ex_*` outputs. The operand mux and `stall_if_id` are same-cycle combinational paths.
- **Load-use sequence**:
  - Cycle N: the load is in EX, and the dependent instruction in ID raises `stall_if_id`.
  - Edge N+1: a bubble is loaded, while ID re-presents the same instruction. The load is now in MEM and the forwarding selects read 1.
  - Edge N+2: the dependent instruction loads with `mem_load_data`.
- **Hazard plus flush**: `branch_flush` in the same cycle as `lu` gives a bubble only. `stall_if_id` stays 0 because the ID instruction is being killed.
- **Freeze**: `stall_in` held for k cycles freezes all `ex_*` outputs for k edges. Hazard detection resumes on the first unfrozen cycle.
- **Reset mid-stall**: the pipeline restarts empty and no pending bubble is remembered.

## Configuration
- Macro `ID_EX_PERF_CNT_EN`.
- **Defined**:
  - Adds outputs `perf_bubbles` and `perf_flushes`, 32 bits each and saturating at 0xFFFFFFFF. Both reset to 0.
  - Each counter increments once per edge on which a load-use bubble, or a flush bubble respectively, is loaded.
  - The two counters are exclusive per edge: a flush takes precedence, and held cycles do not count.
- **Undefined**: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- **Forward select**: `rf_rd0` = 0x11, `mem_alu_y` = 0x22, `mem_load_data` = 0x33, `id_rs0` = 5. With `fwd_a_id` = 0, 3, 1, 2 the next-edge `ex_a` = 0x11, 0x22, 0x33, 0x11. With `id_rs0` = 0 and `fwd_a_id` = 3, `ex_a` = 0.
- **Load-use**: `lw x7` in EX, then `add x8, x7, x1` in ID. `stall_if_id` = 1 for one cycle, then a bubble appears (`ex_valid` = 0, `ex_reg_write` = 0). With `fwd_a_id` = 1 the next edge gives `ex_a` = `mem_load_data` and `ex_rd` = 8.
- **Load to x0**: `lw x0` in EX, then an instruction using `rs0` = 0. No stall.
- **Flush with hazard**: `branch_flush` = 1 together with the load-use condition. `stall_if_id` = 0, a bubble is loaded, and `perf_flushes` increments while `perf_bubbles` does not (macro defined).
- **Freeze**: `stall_in` = 1 for 3 cycles while ID inputs change. `ex_*` stay unchanged, and the ID values in force when `stall_in` falls are loaded on the next edge.
- **Async reset**: `rstn` pulsed low mid-cycle between edges. All outputs read 0 before the next edge, and the counters read 0.
